// File: rtl/perf_ctr_bank.sv
// Multi-channel start/stop cycle counter bank with sticky overflow, global
// snapshot and a one-cycle registered read port.

module perf_ctr_chan #(
  parameter int CTR_WIDTH = 32,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 clear_i,
  output logic [CTR_WIDTH-1:0] cnt_o,
  output logic                 running_o,
  output logic                 ovf_o
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [CTR_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CTR_WIDTH-1:0] CNT_ONE = CTR_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CTR_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // start together with stop in IDLE is a no-op
          if (start_i && !stop_i) begin
            state_d = RUN;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        RUN: begin
          // the stop edge still counts, so start@t / stop@t+k yields k
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
            cnt_d = (SATURATE != 0) ? CNT_MAX : '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (stop_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cnt_o     = cnt_q;
  assign running_o = (state_q == RUN);
  assign ovf_o     = ovf_q;
endmodule

module perf_ctr_bank #(
  parameter int NUM_CH    = 4,
  parameter int CTR_WIDTH = 32,
  parameter int SATURATE  = 0,
  parameter int SEL_WIDTH = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    start,
  input  logic [NUM_CH-1:0]    stop,
  input  logic [NUM_CH-1:0]    clear,
  input  logic                 snap,
  input  logic                 rd_en,
  input  logic [SEL_WIDTH-1:0] rd_sel,
  input  logic                 rd_snap,
  output logic                 rd_valid,
  output logic [CTR_WIDTH-1:0] rd_data,
  output logic                 rd_err,
  output logic [NUM_CH-1:0]    running,
  output logic [NUM_CH-1:0]    overflow
);
  typedef struct packed {
    logic                 vld;
    logic                 err;
    logic [CTR_WIDTH-1:0] data;
  } rd_rsp_t;

  localparam logic [SEL_WIDTH:0] NUM_CH_W = NUM_CH[SEL_WIDTH:0];

  logic [NUM_CH-1:0][CTR_WIDTH-1:0] cnt;
  logic [NUM_CH-1:0][CTR_WIDTH-1:0] snap_q;
  rd_rsp_t                          rsp_q, rsp_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_ctr_chan #(
      .CTR_WIDTH (CTR_WIDTH),
      .SATURATE  (SATURATE)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start[g]),
      .stop_i    (stop[g]),
      .clear_i   (clear[g]),
      .cnt_o     (cnt[g]),
      .running_o (running[g]),
      .ovf_o     (overflow[g])
    );
  end

  // Snapshots capture pre-update counters; only reset touches them otherwise.
  always_ff @(posedge clk) begin
    if (rst)       snap_q <= '0;
    else if (snap) snap_q <= cnt;
  end

  always_comb begin
    rsp_d     = rsp_q;
    rsp_d.vld = 1'b0;
    rsp_d.err = 1'b0;
    if (rd_en) begin
      rsp_d.vld  = 1'b1;
      rsp_d.data = '0;
      if ({1'b0, rd_sel} >= NUM_CH_W) begin
        rsp_d.err = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (rd_sel == i[SEL_WIDTH-1:0])
            rsp_d.data = rd_snap ? snap_q[i] : cnt[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rsp_q <= '0;
    else     rsp_q <= rsp_d;
  end

  assign rd_valid = rsp_q.vld;
  assign rd_err   = rsp_q.err;
  assign rd_data  = rsp_q.data;
endmodule

// File: doc/perf_ctr_bank.md
Name: perf_ctr_bank

Overview:
- Multi-channel runtime/performance counter bank for the TPU control path.
- Each of NUM_CH channels measures the cycle count between its own start and stop events, e.g. instruction issue to synchronisation, or DMA begin to end.
- Adds per-channel clear, sticky overflow, wrap or saturate mode, a global simultaneous snapshot, and a registered read port so the host can sample any channel.

Parameters:
NUM_CH, 4, number of independent counter channels (>=1)
CTR_WIDTH, 32, counter width in bits
SATURATE, 0, 0 = counters wrap at max, 1 = counters saturate at max
SEL_WIDTH, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of rd_sel

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  NUM_CH  per-channel start event
stop  in  NUM_CH  per-channel stop event
clear  in  NUM_CH  per-channel clear
snap  in  1  copy all live counters into the snapshot registers
rd_en  in  1  read request
rd_sel  in  SEL_WIDTH  channel to read
rd_snap  in  1  0 = read live counter, 1 = read snapshot register
rd_valid  out  1  read data valid
rd_data  out  CTR_WIDTH  read data
rd_err  out  1  rd_sel was out of range
running  out  NUM_CH  channel is in RUN state
overflow  out  NUM_CH  sticky overflow flag per channel

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- On reset, every channel goes to IDLE, and all counters, snapshots, overflow, running, rd_valid, rd_data and rd_err are 0.
- Per-channel FSM states: IDLE, RUN. Priority is rst > clear[i] > start/stop.
- IDLE, start=1, stop=0: go to RUN; counter <= 0; overflow[i] <= 0.
- IDLE, start=1, stop=1: stay IDLE; no change.
- IDLE, start=0: stay IDLE; counter holds (stop alone is ignored).
- RUN, stop=0: stay RUN; counter increments.
- RUN, stop=1: go to IDLE; counter still increments on that edge.
- RUN, start alone: ignored (no restart).
- Resulting count: start sampled at edge t and stop sampled at edge t+k gives a final count of exactly k.
- clear[i]: counter <= 0, overflow[i] <= 0, state <= IDLE, whatever the FSM state or the start/stop values.
- Increment at all-ones, SATURATE=0: wraps to 0; overflow[i] <= 1.
- Increment at all-ones, SATURATE=1: holds all-ones; overflow[i] <= 1.
- overflow is sticky: only start-from-IDLE, clear or rst lowers it.
- running[i] is registered and equals (state==RUN).
- snap: on the edge it is sampled, every snapshot[i] <= pre-update counter[i], all channels at once.
- Snapshots are unaffected by clear and start; only rst zeroes them.
- Read latency is 1 cycle. rd_en sampled at edge t gives rd_valid=1 during the following cycle; rd_valid=0 otherwise.
- Read data source: rd_data = snapshot[rd_sel] if rd_snap=1, else the live counter value held before edge t (pre-update).
- rd_sel >= NUM_CH: rd_data=0, rd_err=1, rd_valid=1. rd_err is otherwise 0.
- rd_data holds its last value when rd_valid=0.
- Read and snap sampled on the same edge with rd_snap=1: the read returns the old snapshot.
- Channels are fully independent; simultaneous events on different channels never interact.
- Arithmetic is unsigned, CTR_WIDTH bits, with no carry-out beyond the overflow flag.

Test Plan:
- Reset then start[0] pulse at edge 10 and stop[0] pulse at edge 25; rd_en sel=0 after -> rd_valid next cycle, rd_data=15, running[0] high only during edges 11..25, overflow[0]=0.
- CTR_WIDTH=4, SATURATE=0, start then 17 cycles running -> count wraps to 1, overflow=1. A second start -> count reset to 0, overflow=0.
- CTR_WIDTH=4, SATURATE=1, run 20 cycles -> count holds 15, overflow=1. clear -> 0, IDLE, overflow=0.
- start and stop together in IDLE -> running stays 0, count unchanged. start in RUN (count=7) -> ignored, count continues 8, 9.
- Channels 0 and 2 running with counts 5 and 9; snap pulsed, both keep running, then rd_snap=1 reads -> 5 and 9. Live reads give larger values.
- NUM_CH=3, rd_sel=3 -> rd_valid=1, rd_err=1, rd_data=0. rst asserted mid-run -> all outputs return to 0 the next cycle.
